gpo_seq_ctrl: RTL and testbench

//  Owns the write port of the 4-bit GPO peripheral and shares it between CPU passthrough and a pattern sequencer.
//  The CPU programs a step table, period and length through a 4-word slave window; the block then plays the table out.
//  It issues one GPO write per step, with a programmable number of idle cycles between steps, optionally looping.
//  It sits between the bus decoder and the GPO instance.

---
 rtl/gpo_seq_pkg.sv | 28 ++
 rtl/gpo_seq_regs.sv | 104 ++++++++++
 rtl/gpo_seq_ctrl.sv | 163 ++++++++++++++++
 tb/tb_gpo_seq_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gpo_seq_pkg.sv
// Shared types and register-map constants for the GPO pattern sequencer.
// No logic; no latency; no backpressure.
package gpo_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        WAIT = 2'd2,
        FIN  = 2'd3
    } seq_state_t;

    localparam int DATA_W = 32;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_PERIOD  = 2'd1;
    localparam logic [1:0] ADDR_PATTERN = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    localparam int CTRL_RUN      = 0;
    localparam int CTRL_LOOP     = 1;
    localparam int CTRL_LEN_LSB  = 4;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_DONE     = 1;
    localparam int STAT_OVR      = 2;
    localparam int STAT_STEP_LSB = 4;

endpackage

// File: rtl/gpo_seq_regs.sv
// Slave register window (CTRL/PERIOD/PATTERN/STATUS) with W1C status bits.
// Writes land on the strobe edge; rdata is combinational; never stalls.
module gpo_seq_regs
    import gpo_seq_pkg::*;
#(
    parameter int NUM_STEPS = 8,
    parameter int STEP_W    = 4,
    parameter int PERIOD_W  = 32,
    parameter int IDX_W     = 3
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_ce,
    input  logic                          i_wr_en,
    input  logic [1:0]                    i_addr,
    input  logic [DATA_W-1:0]             i_wdata,
    output logic [DATA_W-1:0]             o_rdata,
    input  logic                          i_busy,
    input  logic [IDX_W-1:0]              i_step,
    input  logic                          i_set_done,
    input  logic                          i_set_ovr,
    input  logic                          i_clr_run,
    output logic                          o_ctrl_wr,
    output logic                          o_run,
    output logic                          o_loop,
    output logic [IDX_W-1:0]              o_len,
    output logic [PERIOD_W-1:0]           o_period,
    output logic [NUM_STEPS*STEP_W-1:0]   o_pattern
);

    logic                        r_run;
    logic                        r_loop;
    logic [IDX_W-1:0]            r_len;
    logic [PERIOD_W-1:0]         r_period;
    logic [NUM_STEPS*STEP_W-1:0] r_pattern;
    logic                        r_done;
    logic                        r_ovr;

    logic w_wr;
    logic w_stat_wr;

    assign w_wr      = i_ce & i_wr_en;
    assign o_ctrl_wr = w_wr & (i_addr == ADDR_CTRL);
    assign w_stat_wr = w_wr & (i_addr == ADDR_STATUS);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_run     <= 1'b0;
            r_loop    <= 1'b0;
            r_len     <= '0;
            r_period  <= '0;
            r_pattern <= '0;
            r_done    <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            // A CPU write to CTRL in the FIN cycle overrides the auto-clear of run.
            if (o_ctrl_wr) begin
                r_run  <= i_wdata[CTRL_RUN];
                r_loop <= i_wdata[CTRL_LOOP];
                r_len  <= i_wdata[CTRL_LEN_LSB +: IDX_W];
            end else if (i_clr_run) begin
                r_run  <= 1'b0;
            end
            if (w_wr && i_addr == ADDR_PERIOD)
                r_period <= i_wdata[PERIOD_W-1:0];
            if (w_wr && i_addr == ADDR_PATTERN)
                r_pattern <= i_wdata[NUM_STEPS*STEP_W-1:0];
            if (i_set_done)
                r_done <= 1'b1;
            else if (w_stat_wr && i_wdata[STAT_DONE])
                r_done <= 1'b0;
            if (i_set_ovr)
                r_ovr <= 1'b1;
            else if (w_stat_wr && i_wdata[STAT_OVR])
                r_ovr <= 1'b0;
        end
    end

    always_comb begin
        o_rdata = '0;
        case (i_addr)
            ADDR_CTRL: begin
                o_rdata[CTRL_RUN]                  = r_run;
                o_rdata[CTRL_LOOP]                 = r_loop;
                o_rdata[CTRL_LEN_LSB +: IDX_W]     = r_len;
            end
            ADDR_PERIOD:  o_rdata[PERIOD_W-1:0]           = r_period;
            ADDR_PATTERN: o_rdata[NUM_STEPS*STEP_W-1:0]   = r_pattern;
            default: begin
                o_rdata[STAT_BUSY]                 = i_busy;
                o_rdata[STAT_DONE]                 = r_done;
                o_rdata[STAT_OVR]                  = r_ovr;
                o_rdata[STAT_STEP_LSB +: IDX_W]    = i_step;
            end
        endcase
    end

    assign o_run     = r_run;
    assign o_loop    = r_loop;
    assign o_len     = r_len;
    assign o_period  = r_period;
    assign o_pattern = r_pattern;

endmodule

// File: rtl/gpo_seq_ctrl.sv
// Shares the GPO write port between CPU passthrough and a step-table sequencer.
// First sequencer strobe one cycle after the run write; steps PERIOD+1 apart; CPU writes while busy are dropped.
module gpo_seq_ctrl
    import gpo_seq_pkg::*;
#(
    parameter int NUM_STEPS = 8,
    parameter int STEP_W    = 4,
    parameter int PERIOD_W  = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_ce,
    input  logic              i_wr_en,
    input  logic [1:0]        i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    input  logic              i_cpu_gpo_ce,
    input  logic              i_cpu_gpo_wr_en,
    input  logic [DATA_W-1:0] i_cpu_gpo_wdata,
    output logic              o_gpo_ce,
    output logic              o_gpo_wr_en,
    output logic [1:0]        o_gpo_addr,
    output logic [DATA_W-1:0] o_gpo_wdata,
    output logic              o_irq_done
);

    localparam int IDX_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

    seq_state_t           r_state;
    logic [IDX_W-1:0]     r_step;
    logic [PERIOD_W-1:0]  r_cnt;

    seq_state_t           w_state_nxt;
    logic [IDX_W-1:0]     w_step_nxt;
    logic [PERIOD_W-1:0]  w_cnt_nxt;
    logic                 w_adv;
    logic                 w_busy;
    logic                 w_start;
    logic                 w_abort;
    logic                 w_ctrl_wr;
    logic                 w_run;
    logic                 w_loop;
    logic [IDX_W-1:0]     w_len;
    logic [PERIOD_W-1:0]  w_period;
    logic [NUM_STEPS*STEP_W-1:0] w_pattern;
    logic [STEP_W-1:0]    w_nib;

    gpo_seq_regs #(
        .NUM_STEPS (NUM_STEPS),
        .STEP_W    (STEP_W),
        .PERIOD_W  (PERIOD_W),
        .IDX_W     (IDX_W)
    ) u_regs (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_ce       (i_ce),
        .i_wr_en    (i_wr_en),
        .i_addr     (i_addr),
        .i_wdata    (i_wdata),
        .o_rdata    (o_rdata),
        .i_busy     (w_busy),
        .i_step     (r_step),
        .i_set_done (r_state == FIN),
        .i_set_ovr  (w_busy & i_cpu_gpo_ce & i_cpu_gpo_wr_en),
        .i_clr_run  (r_state == FIN),
        .o_ctrl_wr  (w_ctrl_wr),
        .o_run      (w_run),
        .o_loop     (w_loop),
        .o_len      (w_len),
        .o_period   (w_period),
        .o_pattern  (w_pattern)
    );

    assign w_busy  = (r_state != IDLE);
    // Look at the incoming CTRL write so the first strobe lands one cycle after it.
    assign w_start = (r_state == IDLE) && (w_ctrl_wr ? i_wdata[CTRL_RUN] : w_run);
    assign w_abort = w_ctrl_wr && !i_wdata[CTRL_RUN] && (r_state == STEP || r_state == WAIT);
    assign w_nib   = w_pattern[int'(r_step)*STEP_W +: STEP_W];

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_cnt_nxt   = r_cnt;
        w_adv       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_nxt = STEP;
                    w_step_nxt  = '0;
                end
            end
            STEP: begin
                w_cnt_nxt = w_period;
                if (w_period != '0)
                    w_state_nxt = WAIT;
                else
                    w_adv = 1'b1;
            end
            WAIT: begin
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt <= PERIOD_W'(1))
                    w_adv = 1'b1;
            end
            default: begin
                w_state_nxt = IDLE;
                w_step_nxt  = '0;
            end
        endcase
        if (w_adv) begin
            if (r_step < w_len) begin
                w_state_nxt = STEP;
                w_step_nxt  = r_step + 1'b1;
            end else if (w_loop) begin
                w_state_nxt = STEP;
                w_step_nxt  = '0;
            end else begin
                w_state_nxt = FIN;
            end
        end
        if (w_abort) begin
            w_state_nxt = IDLE;
            w_step_nxt  = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_step  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        o_gpo_ce    = 1'b0;
        o_gpo_wr_en = 1'b0;
        o_gpo_wdata = '0;
        o_irq_done  = 1'b0;
        if (!i_reset) begin
            case (r_state)
                IDLE: begin
                    o_gpo_ce    = i_cpu_gpo_ce;
                    o_gpo_wr_en = i_cpu_gpo_wr_en;
                    o_gpo_wdata = i_cpu_gpo_wdata;
                end
                STEP: begin
                    o_gpo_ce    = 1'b1;
                    o_gpo_wr_en = 1'b1;
                    o_gpo_wdata = {{(DATA_W-STEP_W){1'b0}}, w_nib};
                end
                FIN:     o_irq_done = 1'b1;
                default: ;
            endcase
        end
    end

    assign o_gpo_addr = 2'd0;

endmodule

// File: tb/tb_gpo_seq_ctrl.sv
// Directed bench for gpo_seq_ctrl: register table plus hand-timed sequencer scenarios.
module tb_gpo_seq_ctrl;
    import gpo_seq_pkg::*;

    logic        clk;
    logic        reset;
    logic        ce, wr_en;
    logic [1:0]  addr;
    logic [31:0] wdata, rdata;
    logic        cpu_ce, cpu_wr;
    logic [31:0] cpu_wdata;
    logic        gpo_ce, gpo_wr_en;
    logic [1:0]  gpo_addr;
    logic [31:0] gpo_wdata;
    logic        irq_done;

    int n_pass = 0;
    int n_chk  = 0;
    logic [3:0] odr_seen = '0;

    gpo_seq_ctrl dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_ce            (ce),
        .i_wr_en         (wr_en),
        .i_addr          (addr),
        .i_wdata         (wdata),
        .o_rdata         (rdata),
        .i_cpu_gpo_ce    (cpu_ce),
        .i_cpu_gpo_wr_en (cpu_wr),
        .i_cpu_gpo_wdata (cpu_wdata),
        .o_gpo_ce        (gpo_ce),
        .o_gpo_wr_en     (gpo_wr_en),
        .o_gpo_addr      (gpo_addr),
        .o_gpo_wdata     (gpo_wdata),
        .o_irq_done      (irq_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ce;
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        ce = 1'b1; wr_en = 1'b1; addr = a; wdata = d;
        @(posedge clk);
        @(negedge clk);
        ce = 1'b0; wr_en = 1'b0; wdata = '0;
    endtask

    task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(name, rdata, exp);
    endtask

    // Per-cycle GPO port check; also tracks what the GPO's ODR would hold.
    task automatic chk_gpo(input string name, input logic e_ce, input logic e_wr,
                           input logic [31:0] e_wd, input logic e_irq);
        #1;
        chk({name, "_ce"},  32'(gpo_ce),    32'(e_ce));
        chk({name, "_wr"},  32'(gpo_wr_en), 32'(e_wr));
        chk({name, "_wd"},  gpo_wdata,      e_wd);
        chk({name, "_irq"}, 32'(irq_done),  32'(e_irq));
        if (gpo_ce && gpo_wr_en) odr_seen = gpo_wdata[3:0];
    endtask

    initial begin
        reset = 1'b1; ce = 0; wr_en = 0; addr = 0; wdata = 0;
        cpu_ce = 0; cpu_wr = 0; cpu_wdata = 0;

        tbl[0]  = '{1'b0, 1'b0, ADDR_CTRL,    32'h0,          32'h0};
        tbl[1]  = '{1'b0, 1'b0, ADDR_PERIOD,  32'h0,          32'h0};
        tbl[2]  = '{1'b0, 1'b0, ADDR_PATTERN, 32'h0,          32'h0};
        tbl[3]  = '{1'b0, 1'b0, ADDR_STATUS,  32'h0,          32'h0};
        tbl[4]  = '{1'b1, 1'b1, ADDR_CTRL,    32'h0000_0072,  32'h0000_0072};
        tbl[5]  = '{1'b1, 1'b1, ADDR_CTRL,    32'hFFFF_FF8A,  32'h0000_0002};
        tbl[6]  = '{1'b1, 1'b1, ADDR_PERIOD,  32'hDEAD_BEEF,  32'hDEAD_BEEF};
        tbl[7]  = '{1'b1, 1'b1, ADDR_PATTERN, 32'h1234_5678,  32'h1234_5678};
        tbl[8]  = '{1'b1, 1'b1, ADDR_STATUS,  32'hFFFF_FFFF,  32'h0};
        tbl[9]  = '{1'b1, 1'b1, ADDR_CTRL,    32'h0,          32'h0};
        tbl[10] = '{1'b1, 1'b1, ADDR_PERIOD,  32'h0,          32'h0};
        tbl[11] = '{1'b0, 1'b1, ADDR_PATTERN, 32'h5555_5555,  32'h1234_5678};

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk_gpo("rst", 1'b0, 1'b0, 32'h0, 1'b0);
        chk("rst_gpo_addr", 32'(gpo_addr), 32'h0);

        // Register table
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].wr) begin
                ce = tbl[i].ce; wr_en = 1'b1; addr = tbl[i].addr; wdata = tbl[i].wdata;
                @(posedge clk);
                @(negedge clk);
                ce = 1'b0; wr_en = 1'b0; wdata = '0;
            end
            rd_chk($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].exp);
        end
        bus_wr(ADDR_PATTERN, 32'h0);

        // 1: four steps spaced PERIOD+1 = 3 cycles
        bus_wr(ADDR_PATTERN, 32'h0000_4321);
        bus_wr(ADDR_PERIOD,  32'd2);
        bus_wr(ADDR_CTRL,    32'h0000_0031);
        addr = ADDR_STATUS;
        for (int k = 0; k < 14; k++) begin
            logic s;
            s = (k % 3 == 0) && (k <= 9);
            chk_gpo($sformatf("t1_k%0d", k), s, s, s ? 32'(k / 3 + 1) : 32'h0, k == 12);
            chk($sformatf("t1_busy_k%0d", k), 32'(rdata[0]), 32'(k < 13));
            tick();
        end
        rd_chk("t1_status", ADDR_STATUS, 32'h2);
        bus_wr(ADDR_STATUS, 32'h2);
        rd_chk("t1_done_clr", ADDR_STATUS, 32'h0);

        // 2: PERIOD=0 gives back-to-back strobes
        bus_wr(ADDR_PERIOD,  32'd0);
        bus_wr(ADDR_PATTERN, 32'h8765_4321);
        bus_wr(ADDR_CTRL,    32'h0000_0071);
        for (int k = 0; k < 10; k++) begin
            chk_gpo($sformatf("t2_k%0d", k), k < 8, k < 8, (k < 8) ? 32'(k + 1) : 32'h0, k == 8);
            tick();
        end
        rd_chk("t2_status", ADDR_STATUS, 32'h2);
        bus_wr(ADDR_STATUS, 32'h2);

        // 3: loop alternates 5,A; abort during a STEP cycle
        bus_wr(ADDR_PATTERN, 32'h0000_00A5);
        bus_wr(ADDR_CTRL,    32'h0000_0013);
        for (int k = 0; k < 11; k++) begin
            chk_gpo($sformatf("t3_k%0d", k), 1'b1, 1'b1, (k % 2 == 1) ? 32'hA : 32'h5, 1'b0);
            if (k < 10) tick();
        end
        bus_wr(ADDR_CTRL, 32'h0);
        for (int k = 0; k < 5; k++) begin
            chk_gpo($sformatf("t3_post%0d", k), 1'b0, 1'b0, 32'h0, 1'b0);
            tick();
        end
        chk("t3_odr_hold", 32'(odr_seen), 32'h5);
        rd_chk("t3_status", ADDR_STATUS, 32'h0);

        // 4: CPU writes dropped while busy, ovr set beats same-cycle W1C
        bus_wr(ADDR_PERIOD,  32'd5);
        bus_wr(ADDR_PATTERN, 32'h1);
        bus_wr(ADDR_CTRL,    32'h1);
        chk_gpo("t4_k0", 1'b1, 1'b1, 32'h1, 1'b0);
        tick();
        cpu_ce = 1'b1; cpu_wr = 1'b1; cpu_wdata = 32'hF;
        chk_gpo("t4_drop", 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        rd_chk("t4_ovr_set", ADDR_STATUS, 32'h5);
        ce = 1'b1; wr_en = 1'b1; addr = ADDR_STATUS; wdata = 32'h4;
        @(posedge clk);
        @(negedge clk);
        ce = 1'b0; wr_en = 1'b0; wdata = '0;
        cpu_ce = 1'b0; cpu_wr = 1'b0; cpu_wdata = '0;
        rd_chk("t4_set_wins", ADDR_STATUS, 32'h5);
        bus_wr(ADDR_STATUS, 32'h4);
        rd_chk("t4_ovr_clr", ADDR_STATUS, 32'h1);
        tick();
        tick();
        chk_gpo("t4_fin", 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        rd_chk("t4_status", ADDR_STATUS, 32'h2);
        bus_wr(ADDR_STATUS, 32'h2);
        cpu_ce = 1'b1; cpu_wr = 1'b1; cpu_wdata = 32'hF;
        chk_gpo("t4_pass", 1'b1, 1'b1, 32'hF, 1'b0);
        tick();
        rd_chk("t4_no_ovr", ADDR_STATUS, 32'h0);
        cpu_wr = 1'b0;
        chk_gpo("t4_pass_rd", 1'b1, 1'b0, 32'hF, 1'b0);
        cpu_ce = 1'b0; cpu_wdata = '0;
        tick();

        // 5: reset in the middle of a WAIT
        bus_wr(ADDR_PERIOD,  32'd10);
        bus_wr(ADDR_PATTERN, 32'h7);
        bus_wr(ADDR_CTRL,    32'h1);
        repeat (3) tick();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk_gpo("t5_rst", 1'b0, 1'b0, 32'h0, 1'b0);
        rd_chk("t5_ctrl",    ADDR_CTRL,    32'h0);
        rd_chk("t5_period",  ADDR_PERIOD,  32'h0);
        rd_chk("t5_pattern", ADDR_PATTERN, 32'h0);
        rd_chk("t5_status",  ADDR_STATUS,  32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_gpo($sformatf("t5_quiet%0d", k), 1'b0, 1'b0, 32'h0, 1'b0);
        end

        // 6: PATTERN rewrite during WAIT, redundant run write while busy
        bus_wr(ADDR_PERIOD,  32'd3);
        bus_wr(ADDR_PATTERN, 32'h21);
        bus_wr(ADDR_CTRL,    32'h11);
        chk_gpo("t6_k0", 1'b1, 1'b1, 32'h1, 1'b0);
        tick();
        bus_wr(ADDR_PATTERN, 32'h91);
        tick();
        tick();
        chk_gpo("t6_k4", 1'b1, 1'b1, 32'h9, 1'b0);
        tick();
        bus_wr(ADDR_CTRL, 32'h11);
        chk_gpo("t6_k6", 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        chk_gpo("t6_k7", 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        chk_gpo("t6_k8", 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        rd_chk("t6_status", ADDR_STATUS, 32'h2);
        rd_chk("t6_ctrl",   ADDR_CTRL,   32'h10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
